// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable synchronized lock, then
// releases the outclk_0 and outclk_1 domain resets in order. Bounded retries on lock
// timeout, sticky fault afterwards, saturating count of lock losses after release.
module pll_reset_sequencer #(
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 100000,
  parameter int unsigned RELEASE_GAP_CYCLES  = 8,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       soft_reset,
  output logic       pll_rst,
  output logic       rst_out0,
  output logic       rst_out1,
  output logic       ready,
  output logic       fault,
  output logic [1:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);

  localparam int unsigned MaxAB  = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ?
                                   PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int unsigned MaxCD  = (LOCK_TIMEOUT_CYCLES > RELEASE_GAP_CYCLES) ?
                                   LOCK_TIMEOUT_CYCLES : RELEASE_GAP_CYCLES;
  localparam int unsigned MaxCyc = (MaxAB > MaxCD) ? MaxAB : MaxCD;
  localparam int unsigned CntW   = $clog2(MaxCyc) + 1;

  localparam logic [CntW-1:0] PllRstLast  = CntW'(PLL_RST_CYCLES - 1);
  localparam logic [CntW-1:0] StableLast  = CntW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast     = CntW'(RELEASE_GAP_CYCLES - 1);
  localparam logic [1:0]      MaxRetries  = 2'(MAX_RETRIES);

  typedef enum logic [2:0] {
    StPllRst,
    StWaitLock,
    StStable,
    StRel0,
    StRun,
    StFault
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      retry_q, retry_d;
  logic [7:0]      loss_q, loss_d;
  logic            locked_meta_q, locked_s_q;
  logic            pll_rst_q, pll_rst_d;
  logic            rst_out0_q, rst_out0_d;
  logic            rst_out1_q, rst_out1_d;
  logic            ready_q, ready_d;
  logic            fault_q, fault_d;
  logic            lock_lost;

  // Two-flop synchronizer for the asynchronous PLL lock indication.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      locked_meta_q <= 1'b0;
      locked_s_q    <= 1'b0;
    end else begin
      locked_meta_q <= pll_locked;
      locked_s_q    <= locked_meta_q;
    end
  end

  // Next-state, retry/loss bookkeeping and shared counter.
  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    loss_d    = loss_q;
    lock_lost = 1'b0;
    if (soft_reset) begin
      state_d = StPllRst;
      retry_d = '0;
    end else begin
      case (state_q)
        StPllRst: begin
          if (cnt_q == PllRstLast) state_d = StWaitLock;
        end
        StWaitLock: begin
          if (locked_s_q) begin
            state_d = StStable;
          end else if (cnt_q == TimeoutLast) begin
            if (retry_q < MaxRetries) begin
              retry_d = retry_q + 2'd1;
              state_d = StPllRst;
            end else begin
              state_d = StFault;
            end
          end
        end
        StStable: begin
          if (!locked_s_q) state_d = StWaitLock;
          else if (cnt_q == StableLast) state_d = StRel0;
        end
        StRel0: begin
          if (!locked_s_q) begin
            lock_lost = 1'b1;
          end else if (cnt_q == GapLast) begin
            state_d = StRun;
            retry_d = '0;
          end
        end
        StRun: begin
          if (!locked_s_q) lock_lost = 1'b1;
        end
        StFault: begin
          state_d = StFault;
        end
        default: state_d = StPllRst;
      endcase
    end

    if (lock_lost) begin
      state_d = StPllRst;
      if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
    end

    // Counter restarts on every state entry, including a soft re-entry of PLL_RST.
    if (soft_reset || (state_d != state_q)) begin
      cnt_d = '0;
    end else if (state_q == StRun || state_q == StFault) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Registered outputs follow the state being entered on this edge.
  always_comb begin
    pll_rst_d  = (state_d == StPllRst) || (state_d == StFault);
    rst_out0_d = !((state_d == StRel0) || (state_d == StRun));
    rst_out1_d = (state_d != StRun);
    ready_d    = (state_d == StRun);
    fault_d    = (state_d == StFault);
  end

  // State, counter and output registers.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q    <= StPllRst;
      cnt_q      <= '0;
      retry_q    <= '0;
      loss_q     <= '0;
      pll_rst_q  <= 1'b1;
      rst_out0_q <= 1'b1;
      rst_out1_q <= 1'b1;
      ready_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      loss_q     <= loss_d;
      pll_rst_q  <= pll_rst_d;
      rst_out0_q <= rst_out0_d;
      rst_out1_q <= rst_out1_d;
      ready_q    <= ready_d;
      fault_q    <= fault_d;
    end
  end

  assign pll_rst       = pll_rst_q;
  assign rst_out0      = rst_out0_q;
  assign rst_out1      = rst_out1_q;
  assign ready         = ready_q;
  assign fault         = fault_q;
  assign retry_cnt     = retry_q;
  assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: cycle model of the sequencing rules plus directed checks.
module tb_pll_reset_sequencer;

  localparam int unsigned Prc = 4;
  localparam int unsigned Lsc = 8;
  localparam int unsigned Toc = 32;
  localparam int unsigned Gap = 2;
  localparam int unsigned Mr  = 2;

  logic       refclk = 1'b0;
  logic       rst = 1'b0;
  logic       pll_locked = 1'b0;
  logic       soft_reset = 1'b0;
  logic       pll_rst, rst_out0, rst_out1, ready, fault;
  logic [1:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  always #5 refclk = ~refclk;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES     (Prc),
    .LOCK_STABLE_CYCLES (Lsc),
    .LOCK_TIMEOUT_CYCLES(Toc),
    .RELEASE_GAP_CYCLES (Gap),
    .MAX_RETRIES        (Mr)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .soft_reset   (soft_reset),
    .pll_rst      (pll_rst),
    .rst_out0     (rst_out0),
    .rst_out1     (rst_out1),
    .ready        (ready),
    .fault        (fault),
    .retry_cnt    (retry_cnt),
    .lock_loss_cnt(lock_loss_cnt)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 PLL reset, 1 waiting for lock, 2 lock stabilising, 3 first domain
  // released, 4 running, 5 fault. m_el counts edges spent in the current phase.
  int m_phase, m_el, m_retry, m_loss;
  bit m_meta, m_ls, mv_ls, mv_lost;

  always @(posedge refclk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_el = 0; m_retry = 0; m_loss = 0; m_meta = 0; m_ls = 0;
    end else begin
      mv_ls   = m_ls;
      mv_lost = 0;
      if (soft_reset) begin
        m_phase = 0; m_el = 0; m_retry = 0;
      end else begin
        case (m_phase)
          0: begin
            m_el++;
            if (m_el == Prc) begin m_phase = 1; m_el = 0; end
          end
          1: begin
            if (mv_ls) begin
              m_phase = 2; m_el = 0;
            end else begin
              m_el++;
              if (m_el == Toc) begin
                m_el = 0;
                if (m_retry < Mr) begin m_retry++; m_phase = 0; end
                else m_phase = 5;
              end
            end
          end
          2: begin
            if (!mv_ls) begin m_phase = 1; m_el = 0; end
            else begin
              m_el++;
              if (m_el == Lsc) begin m_phase = 3; m_el = 0; end
            end
          end
          3: begin
            if (!mv_ls) mv_lost = 1;
            else begin
              m_el++;
              if (m_el == Gap) begin m_phase = 4; m_el = 0; m_retry = 0; end
            end
          end
          4: if (!mv_ls) mv_lost = 1;
          default: ;
        endcase
        if (mv_lost) begin
          m_phase = 0; m_el = 0;
          if (m_loss < 255) m_loss++;
        end
      end
      m_ls   = m_meta;
      m_meta = pll_locked;
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge refclk) begin
    if (chk_en) begin
      chk("pll_rst", 32'(pll_rst), 32'(m_phase == 0 || m_phase == 5));
      chk("rst_out0", 32'(rst_out0), 32'(!(m_phase == 3 || m_phase == 4)));
      chk("rst_out1", 32'(rst_out1), 32'(m_phase != 4));
      chk("ready", 32'(ready), 32'(m_phase == 4));
      chk("fault", 32'(fault), 32'(m_phase == 5));
      chk("retry_cnt", 32'(retry_cnt), 32'(m_retry));
      chk("lock_loss_cnt", 32'(lock_loss_cnt), 32'(m_loss));
    end
  end

  task automatic tick();
    @(negedge refclk);
  endtask

  task automatic wait_ready(input string name);
    for (int i = 0; i < 100; i++) begin
      if (ready === 1'b1) break;
      tick();
    end
    chk(name, 32'(ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    #1 rst = 1'b1;
    chk_en = 1'b1;
    tick(); tick();
    chk("rst pll_rst", 32'(pll_rst), 32'd1);
    chk("rst rst_out0", 32'(rst_out0), 32'd1);
    chk("rst rst_out1", 32'(rst_out1), 32'd1);
    chk("rst ready", 32'(ready), 32'd0);
    chk("rst fault", 32'(fault), 32'd0);
    chk("rst retry", 32'(retry_cnt), 32'd0);
    chk("rst loss", 32'(lock_loss_cnt), 32'd0);

    // 1. Nominal
    rst = 1'b0;
    repeat (3) tick();
    chk("t1 pll_rst held", 32'(pll_rst), 32'd1);
    tick();
    chk("t1 pll_rst drop", 32'(pll_rst), 32'd0);
    repeat (6) tick();
    pll_locked = 1'b1;
    repeat (10) tick();
    chk("t1 rst_out0 E+9", 32'(rst_out0), 32'd1);
    tick();
    chk("t1 rst_out0 E+10", 32'(rst_out0), 32'd0);
    chk("t1 rst_out1 E+10", 32'(rst_out1), 32'd1);
    tick();
    chk("t1 ready E+11", 32'(ready), 32'd0);
    tick();
    chk("t1 rst_out1 E+12", 32'(rst_out1), 32'd0);
    chk("t1 ready E+12", 32'(ready), 32'd1);
    chk("t1 retry", 32'(retry_cnt), 32'd0);

    // 2. One-cycle lock glitch during stabilisation
    soft_reset = 1'b1; pll_locked = 1'b0;
    tick();
    soft_reset = 1'b0;
    chk("t2 soft pll_rst", 32'(pll_rst), 32'd1);
    repeat (10) tick();
    pll_locked = 1'b1;
    repeat (7) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    repeat (3) tick();
    chk("t2 no release E+10", 32'(rst_out0), 32'd1);
    repeat (7) tick();
    chk("t2 rst_out0 E+17", 32'(rst_out0), 32'd1);
    tick();
    chk("t2 rst_out0 E+18", 32'(rst_out0), 32'd0);
    repeat (2) tick();
    chk("t2 ready E+20", 32'(ready), 32'd1);
    chk("t2 retry", 32'(retry_cnt), 32'd0);

    // 3. Timeouts into fault
    soft_reset = 1'b1; pll_locked = 1'b0;
    tick();
    soft_reset = 1'b0;
    repeat (36) tick();
    chk("t3 retry after 1st", 32'(retry_cnt), 32'd1);
    chk("t3 pll_rst 2nd pulse", 32'(pll_rst), 32'd1);
    repeat (36) tick();
    chk("t3 retry after 2nd", 32'(retry_cnt), 32'd2);
    repeat (35) tick();
    chk("t3 fault before", 32'(fault), 32'd0);
    tick();
    chk("t3 fault", 32'(fault), 32'd1);
    chk("t3 fault retry", 32'(retry_cnt), 32'd2);
    chk("t3 fault pll_rst", 32'(pll_rst), 32'd1);
    repeat (5) tick();
    chk("t3 fault sticky", 32'(fault), 32'd1);
    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;
    chk("t3 soft fault", 32'(fault), 32'd0);
    chk("t3 soft retry", 32'(retry_cnt), 32'd0);
    chk("t3 soft pll_rst", 32'(pll_rst), 32'd1);

    // 4. Lock loss in RUN
    pll_locked = 1'b1;
    wait_ready("t4 wait ready");
    pll_locked = 1'b0;
    repeat (2) tick();
    chk("t4 ready after 2", 32'(ready), 32'd1);
    tick();
    chk("t4 ready after 3", 32'(ready), 32'd0);
    chk("t4 rst_out0", 32'(rst_out0), 32'd1);
    chk("t4 rst_out1", 32'(rst_out1), 32'd1);
    chk("t4 loss", 32'(lock_loss_cnt), 32'd1);

    // 5. soft_reset coincides with lock loss
    pll_locked = 1'b1;
    wait_ready("t5 wait ready");
    pll_locked = 1'b0;
    repeat (2) tick();
    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;
    chk("t5 loss unchanged", 32'(lock_loss_cnt), 32'd1);
    chk("t5 pll_rst", 32'(pll_rst), 32'd1);
    chk("t5 ready", 32'(ready), 32'd0);

    // 4 continued: saturation
    for (int k = 0; k < 299; k++) begin
      pll_locked = 1'b1;
      wait_ready("t4 loop ready");
      pll_locked = 1'b0;
      repeat (3) tick();
    end
    chk("t4 loss saturated", 32'(lock_loss_cnt), 32'd255);
    pll_locked = 1'b1;
    wait_ready("t4 final ready");

    // 6. rst mid-REL0
    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (rst_out0 === 1'b0) break;
      tick();
    end
    chk("t6 in rel0 rst_out0", 32'(rst_out0), 32'd0);
    chk("t6 in rel0 rst_out1", 32'(rst_out1), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6 async pll_rst", 32'(pll_rst), 32'd1);
    chk("t6 async rst_out0", 32'(rst_out0), 32'd1);
    chk("t6 async rst_out1", 32'(rst_out1), 32'd1);
    chk("t6 async loss", 32'(lock_loss_cnt), 32'd0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("t6 pll_rst held", 32'(pll_rst), 32'd1);
    tick();
    chk("t6 pll_rst drop", 32'(pll_rst), 32'd0);
    wait_ready("t6 wait ready");

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
